// File: rtl/cpu_wb_port_arbiter.sv
// Writeback port arbiter: the ALU, memory-load returns and buffered multiply results
// share the single registered write port of the register bank, with anti-starvation forcing.
module cpu_wb_port_arbiter #(
   parameter int REG_WIDTH    = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int MUL_FIFO_DEP = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alu_wb_valid,
   input  logic [REG_ADDR_W-1:0] alu_wb_reg,
   input  logic [REG_WIDTH-1:0]  alu_wb_data,
   output logic                  alu_stall,
   input  logic                  mem_wb_valid,
   input  logic [REG_ADDR_W-1:0] mem_wb_reg,
   input  logic [REG_WIDTH-1:0]  mem_wb_data,
   output logic                  mem_wb_ready,
   input  logic                  mul_wb_valid,
   input  logic [REG_ADDR_W-1:0] mul_wb_reg,
   input  logic [REG_WIDTH-1:0]  mul_wb_data,
   output logic                  mul_wb_ready,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_reg,
   output logic [REG_WIDTH-1:0]  wr_data
);
   localparam int PTR_W   = $clog2(MUL_FIFO_DEP);
   localparam int CNT_W   = $clog2(MUL_FIFO_DEP + 1);
   localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int NSRC    = 2;
   localparam int SRC_MEM = 0;
   localparam int SRC_MUL = 1;
   localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(MUL_FIFO_DEP);
   localparam logic [WAIT_W-1:0] WAIT_MAX      = WAIT_W'(STARVE_LIMIT);

   typedef enum logic {
      RR_MEM = 1'b0,
      RR_MUL = 1'b1
   } rr_state_t;

   rr_state_t             rr_reg, rr_next;
   logic [NSRC-1:0]       src_req;
   logic [NSRC-1:0]       src_forced;
   logic [NSRC-1:0]       src_grant;
   logic [NSRC-1:0]       rr_pick;
   logic                  grant_alu;

   logic [REG_ADDR_W-1:0] fifo_reg_mem [MUL_FIFO_DEP];
   logic [REG_WIDTH-1:0]  fifo_data_mem [MUL_FIFO_DEP];
   logic [PTR_W-1:0]      rd_ptr_reg, wr_ptr_reg;
   logic [CNT_W-1:0]      fifo_cnt_reg, fifo_cnt_next;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [REG_ADDR_W-1:0] head_idx;
   logic [REG_WIDTH-1:0]  head_data;

   logic                  wr_en_reg, wr_en_next;
   logic [REG_ADDR_W-1:0] wr_idx_reg, wr_idx_next;
   logic [REG_WIDTH-1:0]  wr_data_reg, wr_data_next;

   // ---------------- MUL result FIFO ----------------
   // Ready comes from the registered count, so a pop while full cannot reopen it this cycle.
   assign fifo_full    = (fifo_cnt_reg == FIFO_FULL_CNT);
   assign fifo_empty   = (fifo_cnt_reg == '0);
   assign fifo_push    = mul_wb_valid && !fifo_full && !reset;
   assign fifo_pop     = src_grant[SRC_MUL];
   assign mul_wb_ready = !fifo_full;
   assign head_idx     = fifo_reg_mem[rd_ptr_reg];
   assign head_data    = fifo_data_mem[rd_ptr_reg];

   always_comb begin
      fifo_cnt_next = fifo_cnt_reg;
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
         2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
         default: fifo_cnt_next = fifo_cnt_reg;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else begin
         fifo_cnt_reg <= fifo_cnt_next;
         if (fifo_push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (fifo_pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (fifo_push) begin
         fifo_reg_mem[wr_ptr_reg]  <= mul_wb_reg;
         fifo_data_mem[wr_ptr_reg] <= mul_wb_data;
      end
   end

   // ---------------- Requests and starvation counters ----------------
   assign src_req[SRC_MEM] = mem_wb_valid && !reset;
   assign src_req[SRC_MUL] = !fifo_empty && !reset;

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_wait
         logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

         always_comb begin
            wait_cnt_next = '0;
            if (src_req[gi] && !src_grant[gi])
               wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? WAIT_MAX : wait_cnt_reg + 1'b1;
         end

         always_ff @(posedge clock) begin
            if (reset)
               wait_cnt_reg <= '0;
            else
               wait_cnt_reg <= wait_cnt_next;
         end

         assign src_forced[gi] = src_req[gi] && (wait_cnt_reg == WAIT_MAX);
      end
   endgenerate

   // ---------------- Grant ----------------
   assign rr_pick[SRC_MEM] = (rr_reg == RR_MEM);
   assign rr_pick[SRC_MUL] = (rr_reg == RR_MUL);

   always_comb begin
      grant_alu = 1'b0;
      src_grant = '0;
      if (&src_forced) begin
         src_grant = rr_pick;
      end else if (|src_forced) begin
         src_grant = src_forced;
      end else if (alu_wb_valid && !reset) begin
         grant_alu = 1'b1;
      end else if (&src_req) begin
         src_grant = rr_pick;
      end else begin
         src_grant = src_req;
      end
   end

   assign alu_stall    = alu_wb_valid && !grant_alu && !reset;
   assign mem_wb_ready = src_grant[SRC_MEM];

   // Pointer moves to whichever of MEM/MUL did not just win.
   always_comb begin
      rr_next = rr_reg;
      if (src_grant[SRC_MEM])
         rr_next = RR_MUL;
      else if (src_grant[SRC_MUL])
         rr_next = RR_MEM;
   end

   always_ff @(posedge clock) begin
      if (reset)
         rr_reg <= RR_MEM;
      else
         rr_reg <= rr_next;
   end

   // ---------------- Registered write port ----------------
   always_comb begin
      wr_en_next   = grant_alu || (|src_grant);
      wr_idx_next  = wr_idx_reg;
      wr_data_next = wr_data_reg;
      if (grant_alu) begin
         wr_idx_next  = alu_wb_reg;
         wr_data_next = alu_wb_data;
      end else if (src_grant[SRC_MEM]) begin
         wr_idx_next  = mem_wb_reg;
         wr_data_next = mem_wb_data;
      end else if (src_grant[SRC_MUL]) begin
         wr_idx_next  = head_idx;
         wr_data_next = head_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_en_reg   <= 1'b0;
         wr_idx_reg  <= '0;
         wr_data_reg <= '0;
      end else begin
         wr_en_reg   <= wr_en_next;
         wr_idx_reg  <= wr_idx_next;
         wr_data_reg <= wr_data_next;
      end
   end

   assign wr_en   = wr_en_reg;
   assign wr_reg  = wr_idx_reg;
   assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_cpu_wb_port_arbiter.sv
// Bench for cpu_wb_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_cpu_wb_port_arbiter;
   localparam int RW = 32;
   localparam int AW = 5;
   localparam int DEP = 2;
   localparam int LIMIT = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          alu_wb_valid, mem_wb_valid, mul_wb_valid;
   logic [AW-1:0] alu_wb_reg, mem_wb_reg, mul_wb_reg;
   logic [RW-1:0] alu_wb_data, mem_wb_data, mul_wb_data;
   logic          alu_stall, mem_wb_ready, mul_wb_ready, wr_en;
   logic [AW-1:0] wr_reg;
   logic [RW-1:0] wr_data;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state
   int            m_wait [2];
   int            m_rr;
   logic [AW-1:0] q_reg [$];
   logic [RW-1:0] q_data [$];
   int            e_win;
   logic          e_stall, e_mem_rdy, e_mul_rdy, e_wr_en;
   logic [AW-1:0] e_wr_reg;
   logic [RW-1:0] e_wr_data;

   // Observed DUT values
   logic          o_stall, o_mem_rdy, o_mul_rdy, o_wr_en;
   logic [AW-1:0] o_wr_reg;
   logic [RW-1:0] o_wr_data;

   cpu_wb_port_arbiter #(
      .REG_WIDTH(RW), .REG_ADDR_W(AW), .MUL_FIFO_DEP(DEP), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clock(clock), .reset(reset),
      .alu_wb_valid(alu_wb_valid), .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
      .alu_stall(alu_stall),
      .mem_wb_valid(mem_wb_valid), .mem_wb_reg(mem_wb_reg), .mem_wb_data(mem_wb_data),
      .mem_wb_ready(mem_wb_ready),
      .mul_wb_valid(mul_wb_valid), .mul_wb_reg(mul_wb_reg), .mul_wb_data(mul_wb_data),
      .mul_wb_ready(mul_wb_ready),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data)
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // winner: 0 none, 1 ALU, 2 MEM, 3 MUL
   function automatic void model_eval();
      bit mem_req, mul_req, mem_f, mul_f;
      mem_req = mem_wb_valid;
      mul_req = q_reg.size() > 0;
      mem_f = mem_req && (m_wait[0] == LIMIT);
      mul_f = mul_req && (m_wait[1] == LIMIT);
      if (mem_f && mul_f)           e_win = (m_rr == 0) ? 2 : 3;
      else if (mem_f)               e_win = 2;
      else if (mul_f)               e_win = 3;
      else if (alu_wb_valid)        e_win = 1;
      else if (mem_req && mul_req)  e_win = (m_rr == 0) ? 2 : 3;
      else if (mem_req)             e_win = 2;
      else if (mul_req)             e_win = 3;
      else                          e_win = 0;
      e_stall   = alu_wb_valid && (e_win != 1);
      e_mem_rdy = (e_win == 2);
      e_mul_rdy = (q_reg.size() < DEP);
   endfunction

   function automatic void model_commit();
      bit mem_req, mul_req;
      mem_req = mem_wb_valid;
      mul_req = q_reg.size() > 0;
      e_wr_en = (e_win != 0);
      case (e_win)
         1: begin e_wr_reg = alu_wb_reg; e_wr_data = alu_wb_data; end
         2: begin e_wr_reg = mem_wb_reg; e_wr_data = mem_wb_data; end
         3: begin e_wr_reg = q_reg.pop_front(); e_wr_data = q_data.pop_front(); end
         default: ;
      endcase
      m_wait[0] = (mem_req && e_win != 2) ? ((m_wait[0] < LIMIT) ? m_wait[0] + 1 : LIMIT) : 0;
      m_wait[1] = (mul_req && e_win != 3) ? ((m_wait[1] < LIMIT) ? m_wait[1] + 1 : LIMIT) : 0;
      if (e_win == 2) m_rr = 1;
      else if (e_win == 3) m_rr = 0;
      if (mul_wb_valid && e_mul_rdy) begin
         q_reg.push_back(mul_wb_reg);
         q_data.push_back(mul_wb_data);
      end
   endfunction

   function automatic void model_reset();
      q_reg.delete();
      q_data.delete();
      m_wait[0] = 0;
      m_wait[1] = 0;
      m_rr = 0;
      e_wr_en = 1'b0;
      e_wr_reg = '0;
      e_wr_data = '0;
      e_stall = 1'b0;
      e_mem_rdy = 1'b0;
   endfunction

   task automatic set_idle();
      alu_wb_valid = 1'b0; alu_wb_reg = '0; alu_wb_data = '0;
      mem_wb_valid = 1'b0; mem_wb_reg = '0; mem_wb_data = '0;
      mul_wb_valid = 1'b0; mul_wb_reg = '0; mul_wb_data = '0;
   endtask

   // One clock: sample combinational outputs at negedge, registered ones #1 after posedge.
   task automatic run_cycle();
      @(negedge clock);
      o_stall   = alu_stall;
      o_mem_rdy = mem_wb_ready;
      o_mul_rdy = mul_wb_ready;
      model_eval();
      model_commit();
      @(posedge clock);
      #1;
      o_wr_en   = wr_en;
      o_wr_reg  = wr_reg;
      o_wr_data = wr_data;
      if (o_wr_en === 1'b1)
         $display("[%0t] write reg=%0d data=%h", $time, o_wr_reg, o_wr_data);
   endtask

   // One reset cycle; comb outputs sampled while reset is high.
   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      o_stall   = alu_stall;
      o_mem_rdy = mem_wb_ready;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      o_wr_en   = wr_en;
      o_wr_reg  = wr_reg;
      o_wr_data = wr_data;
      o_mul_rdy = mul_wb_ready;
      $display("[%0t] reset applied", $time);
   endtask

   task automatic test_reset();
      set_idle();
      do_reset();
      n_cmp++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", o_wr_en); end
      n_cmp++; if (o_wr_reg !== '0) begin n_fail++; $display("FAIL rst_wr_reg: got %0d want 0", o_wr_reg); end
      n_cmp++; if (o_wr_data !== '0) begin n_fail++; $display("FAIL rst_wr_data: got %h want 0", o_wr_data); end
      n_cmp++; if (o_mul_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mul_ready: got %b want 1", o_mul_rdy); end
      n_cmp++; if (mem_wb_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready: got %b want 0", mem_wb_ready); end
      n_cmp++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_alu_stall: got %b want 0", alu_stall); end
   endtask

   task automatic test_alu_only();
      set_idle();
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd3; alu_wb_data = 32'hDEADBEEF;
      run_cycle();
      n_cmp++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", o_stall); end
      n_cmp++; if (o_wr_en !== 1'b1) begin n_fail++; $display("FAIL alu_wr_en: got %b want 1", o_wr_en); end
      n_cmp++; if (o_wr_reg !== 5'd3) begin n_fail++; $display("FAIL alu_wr_reg: got %0d want 3", o_wr_reg); end
      n_cmp++; if (o_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wr_data: got %h want deadbeef", o_wr_data); end
      set_idle();
      run_cycle();
      n_cmp++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_wr_en: got %b want 0", o_wr_en); end
      n_cmp++; if (o_wr_reg !== 5'd3) begin n_fail++; $display("FAIL idle_hold_reg: got %0d want 3", o_wr_reg); end
   endtask

   task automatic test_mem_mul_rr();
      set_idle();
      mul_wb_valid = 1'b1; mul_wb_reg = 5'd6; mul_wb_data = 32'h0000_6666;
      run_cycle();
      mul_wb_valid = 1'b0;
      mem_wb_valid = 1'b1; mem_wb_reg = 5'd5; mem_wb_data = 32'h0000_5555;
      run_cycle();
      n_cmp++; if (o_mem_rdy !== 1'b1) begin n_fail++; $display("FAIL rr_mem_ready: got %b want 1", o_mem_rdy); end
      n_cmp++; if (o_wr_reg !== 5'd5) begin n_fail++; $display("FAIL rr_first_reg: got %0d want 5", o_wr_reg); end
      mem_wb_valid = 1'b0;
      run_cycle();
      n_cmp++; if (o_wr_reg !== 5'd6 || o_wr_en !== 1'b1) begin n_fail++; $display("FAIL rr_second_reg: got %0d en %b want 6 en 1", o_wr_reg, o_wr_en); end
      n_cmp++; if (o_wr_data !== 32'h0000_6666) begin n_fail++; $display("FAIL rr_second_data: got %h want 00006666", o_wr_data); end
      mul_wb_valid = 1'b1; mul_wb_reg = 5'd9; mul_wb_data = 32'h0000_9999;
      run_cycle();
      mul_wb_valid = 1'b0;
      mem_wb_valid = 1'b1; mem_wb_reg = 5'd10; mem_wb_data = 32'h0000_AAAA;
      run_cycle();
      n_cmp++; if (o_mem_rdy !== 1'b1) begin n_fail++; $display("FAIL rr_again_mem_ready: got %b want 1", o_mem_rdy); end
      n_cmp++; if (o_wr_reg !== 5'd10) begin n_fail++; $display("FAIL rr_again_reg: got %0d want 10", o_wr_reg); end
      mem_wb_valid = 1'b0;
      run_cycle();
      n_cmp++; if (o_wr_reg !== 5'd9) begin n_fail++; $display("FAIL rr_again_mul_reg: got %0d want 9", o_wr_reg); end
      set_idle();
   endtask

   task automatic test_starve_alu();
      set_idle();
      mem_wb_valid = 1'b1; mem_wb_reg = 5'd7; mem_wb_data = 32'h0000_7777;
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd1;
      for (int c = 0; c < 4; c++) begin
         alu_wb_data = 32'hA000_0000 + 32'(c);
         run_cycle();
         n_cmp++; if (o_stall !== 1'b0 || o_mem_rdy !== 1'b0) begin n_fail++; $display("FAIL starve_c%0d: stall %b ready %b want 0 0", c, o_stall, o_mem_rdy); end
         n_cmp++; if (o_wr_data !== 32'hA000_0000 + 32'(c)) begin n_fail++; $display("FAIL starve_alu_c%0d: got %h want %h", c, o_wr_data, 32'hA000_0000 + 32'(c)); end
      end
      alu_wb_data = 32'hA000_0004;
      run_cycle();
      n_cmp++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %b want 1", o_stall); end
      n_cmp++; if (o_mem_rdy !== 1'b1) begin n_fail++; $display("FAIL starve_mem_ready: got %b want 1", o_mem_rdy); end
      n_cmp++; if (o_wr_reg !== 5'd7) begin n_fail++; $display("FAIL starve_wr_reg: got %0d want 7", o_wr_reg); end
      mem_wb_valid = 1'b0;
      run_cycle();
      n_cmp++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b want 0", o_stall); end
      n_cmp++; if (o_wr_data !== 32'hA000_0004) begin n_fail++; $display("FAIL starve_held_alu: got %h want a0000004", o_wr_data); end
      set_idle();
   endtask

   task automatic test_fifo_full();
      set_idle();
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd2; alu_wb_data = 32'h0000_0002;
      mul_wb_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         mul_wb_reg  = (c < 2) ? AW'(20 + c) : 5'd22;
         mul_wb_data = (c < 2) ? 32'h1111_0001 + 32'(c) : 32'h1111_0003;
         run_cycle();
         n_cmp++; if (o_mul_rdy !== (c < 2)) begin n_fail++; $display("FAIL fifo_ready_c%0d: got %b want %b", c, o_mul_rdy, (c < 2)); end
      end
      alu_wb_valid = 1'b0;
      run_cycle();
      n_cmp++; if (o_mul_rdy !== 1'b0) begin n_fail++; $display("FAIL fifo_pop_full_ready: got %b want 0", o_mul_rdy); end
      n_cmp++; if (o_wr_reg !== 5'd20 || o_wr_data !== 32'h1111_0001) begin n_fail++; $display("FAIL fifo_order0: got %0d/%h want 20/11110001", o_wr_reg, o_wr_data); end
      run_cycle();
      n_cmp++; if (o_mul_rdy !== 1'b1) begin n_fail++; $display("FAIL fifo_ready_back: got %b want 1", o_mul_rdy); end
      n_cmp++; if (o_wr_reg !== 5'd21 || o_wr_data !== 32'h1111_0002) begin n_fail++; $display("FAIL fifo_order1: got %0d/%h want 21/11110002", o_wr_reg, o_wr_data); end
      mul_wb_valid = 1'b0;
      run_cycle();
      n_cmp++; if (o_wr_reg !== 5'd22 || o_wr_data !== 32'h1111_0003) begin n_fail++; $display("FAIL fifo_order2: got %0d/%h want 22/11110003", o_wr_reg, o_wr_data); end
      set_idle();
   endtask

   task automatic test_reset_mid();
      set_idle();
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd4; alu_wb_data = 32'h0000_0004;
      mem_wb_valid = 1'b1; mem_wb_reg = 5'd26; mem_wb_data = 32'h0000_2626;
      mul_wb_valid = 1'b1; mul_wb_reg = 5'd25; mul_wb_data = 32'h0000_2525;
      run_cycle();
      mul_wb_reg = 5'd27; mul_wb_data = 32'h0000_2727;
      run_cycle();
      alu_wb_valid = 1'b0; mul_wb_valid = 1'b0;
      do_reset();
      n_cmp++; if (o_mem_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_ready: got %b want 0", o_mem_rdy); end
      n_cmp++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %b want 0", o_wr_en); end
      n_cmp++; if (o_mul_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_mul_ready: got %b want 1", o_mul_rdy); end
      mem_wb_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         run_cycle();
         n_cmp++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_discard_c%0d: wr_en %b reg %0d want 0", c, o_wr_en, o_wr_reg); end
      end
   endtask

   task automatic test_dual_starve();
      set_idle();
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd8; alu_wb_data = 32'h0000_0808;
      mul_wb_valid = 1'b1; mul_wb_reg = 5'd12; mul_wb_data = 32'h0000_0C0C;
      run_cycle();
      mul_wb_valid = 1'b0;
      mem_wb_valid = 1'b1; mem_wb_reg = 5'd11; mem_wb_data = 32'h0000_0B0B;
      for (int c = 1; c < 5; c++) begin
         run_cycle();
         n_cmp++; if (o_stall !== 1'b0 || o_mem_rdy !== 1'b0) begin n_fail++; $display("FAIL dual_wait_c%0d: stall %b ready %b want 0 0", c, o_stall, o_mem_rdy); end
      end
      run_cycle();
      n_cmp++; if (o_stall !== 1'b1 || o_mem_rdy !== 1'b1) begin n_fail++; $display("FAIL dual_first: stall %b ready %b want 1 1", o_stall, o_mem_rdy); end
      n_cmp++; if (o_wr_reg !== 5'd11) begin n_fail++; $display("FAIL dual_first_reg: got %0d want 11", o_wr_reg); end
      mem_wb_valid = 1'b0;
      run_cycle();
      n_cmp++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL dual_second_stall: got %b want 1", o_stall); end
      n_cmp++; if (o_wr_reg !== 5'd12 || o_wr_data !== 32'h0000_0C0C) begin n_fail++; $display("FAIL dual_second: got %0d/%h want 12/00000c0c", o_wr_reg, o_wr_data); end
      run_cycle();
      n_cmp++; if (o_wr_reg !== 5'd8 || o_stall !== 1'b0) begin n_fail++; $display("FAIL dual_alu_resume: reg %0d stall %b want 8 0", o_wr_reg, o_stall); end
      set_idle();
   endtask

   task automatic test_random();
      set_idle();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (!(alu_wb_valid && e_stall)) begin
            alu_wb_valid = ($urandom_range(0, 9) < 6);
            alu_wb_reg   = AW'($urandom);
            alu_wb_data  = $urandom;
         end
         if (!(mem_wb_valid && !e_mem_rdy)) begin
            mem_wb_valid = ($urandom_range(0, 9) < 3);
            mem_wb_reg   = AW'($urandom);
            mem_wb_data  = $urandom;
         end
         mul_wb_valid = ($urandom_range(0, 9) < 4);
         mul_wb_reg   = AW'($urandom);
         mul_wb_data  = $urandom;
         if (i == 200) begin
            do_reset();
            n_cmp++; if (o_wr_en !== 1'b0) begin n_fail++; $display("FAIL rnd_reset_wr_en: got %b want 0", o_wr_en); end
         end
         run_cycle();
         n_cmp++; if (o_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall i=%0d: got %b want %b", i, o_stall, e_stall); end
         n_cmp++; if (o_mem_rdy !== e_mem_rdy) begin n_fail++; $display("FAIL rnd_mem_ready i=%0d: got %b want %b", i, o_mem_rdy, e_mem_rdy); end
         n_cmp++; if (o_mul_rdy !== e_mul_rdy) begin n_fail++; $display("FAIL rnd_mul_ready i=%0d: got %b want %b", i, o_mul_rdy, e_mul_rdy); end
         n_cmp++; if (o_wr_en !== e_wr_en) begin n_fail++; $display("FAIL rnd_wr_en i=%0d: got %b want %b", i, o_wr_en, e_wr_en); end
         n_cmp++; if (o_wr_reg !== e_wr_reg || o_wr_data !== e_wr_data) begin n_fail++; $display("FAIL rnd_wr i=%0d: got %0d/%h want %0d/%h", i, o_wr_reg, o_wr_data, e_wr_reg, e_wr_data); end
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      model_reset();
      test_reset();
      test_alu_only();
      test_mem_mul_rr();
      test_starve_alu();
      test_fifo_full();
      test_reset_mid();
      test_dual_starve();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
